// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM encoding, prescaler default,
// BCD digit limits and the packed display-time layout.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2
    } state_e;

    localparam int PRESCALE_DEFAULT = 10000;
    localparam int UNITS_MAX        = 9;
    localparam int TENS_MAX         = 5;

    typedef struct packed {
        logic [2:0] min_x0;
        logic [3:0] min_0x;
        logic [2:0] sec_x0;
        logic [3:0] sec_0x;
        logic [3:0] ces_x0;
        logic [3:0] ces_0x;
    } bcd_time_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the ripple counter: counts 0..MAX on carry_in, raises
// carry_out in the same cycle it wraps, and zeroes on clear.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = UNITS_MAX,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         res,
    input  logic         carry_in,
    input  logic         clear,
    output logic [W-1:0] digit,
    output logic         carry_out
);

    logic [W-1:0] digit_q, digit_d;
    logic         at_max;

    always_comb begin
        // NOTE: next-state defaults to the current value up front, so no path leaves digit_d unassigned and no latch is inferred.
        digit_d = digit_q;
        at_max  = (digit_q == W'(MAX));
        if (clear) begin
            digit_d = '0;
        end else if (carry_in) begin
            digit_d = at_max ? '0 : digit_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        // NOTE: state is written with <= so every flop samples values from before the edge.
        if (!res) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = carry_in & at_max;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch top: button synchronisers, 10 ms prescaler with square-wave
// output, six-digit BCD ripple counter, STOPPED/RUNNING/LAP FSM, display regs.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ena,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic       clk_div,
    output logic [2:0] min_X0,
    output logic [3:0] min_0X,
    output logic [2:0] sec_X0,
    output logic [3:0] sec_0X,
    output logic [3:0] ces_X0,
    output logic [3:0] ces_0X,
    output logic       running,
    output logic       lap_active
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(PRESCALE / 2);

    // Button vectors are ordered {clear, start_stop, lap}.
    logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d, pulse;
    logic          clear_p, start_p, lap_p;
    logic [PW-1:0] pre_q, pre_d;
    logic          clk_div_q, clk_div_d;
    logic          tick, count_en, zero_time;

    state_e        state_q, state_d;
    bcd_time_t     lap_q, lap_d, disp_q, disp_d, live;
    logic          running_q, running_d, lap_active_q, lap_active_d;

    logic [3:0]    d_ces_0x, d_ces_x0, d_sec_0x, d_min_0x;
    logic [2:0]    d_sec_x0, d_min_x0;
    logic          c_ces_0x, c_ces_x0, c_sec_0x, c_sec_x0, c_min_0x, carry_unused;

    assign pulse   = ena ? (sync2_q & ~edge_q) : 3'b000;
    assign clear_p = pulse[2];
    assign start_p = pulse[1];
    assign lap_p   = pulse[0];

    assign tick     = ena && (pre_q == PRE_LAST);
    assign count_en = tick && (state_q != ST_STOPPED);

    always_comb begin
        sync1_d = sync1_q;
        sync2_d = sync2_q;
        edge_d  = edge_q;
        pre_d   = pre_q;
        if (ena) begin
            sync1_d = {clear, start_stop, lap};
            sync2_d = sync1_q;
            edge_d  = sync2_q;
            pre_d   = (zero_time || tick) ? '0 : pre_q + PW'(1);
        end
        clk_div_d = (pre_d < PRE_HALF);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            edge_q    <= '0;
            pre_q     <= '0;
            clk_div_q <= 1'b1;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            edge_q    <= edge_d;
            pre_q     <= pre_d;
            clk_div_q <= clk_div_d;
        end
    end

    bcd_digit #(.MAX(UNITS_MAX)) u_ces_0x (
        .clk(clk), .res(res), .carry_in(count_en), .clear(zero_time),
        .digit(d_ces_0x), .carry_out(c_ces_0x)
    );
    bcd_digit #(.MAX(UNITS_MAX)) u_ces_x0 (
        .clk(clk), .res(res), .carry_in(c_ces_0x), .clear(zero_time),
        .digit(d_ces_x0), .carry_out(c_ces_x0)
    );
    bcd_digit #(.MAX(UNITS_MAX)) u_sec_0x (
        .clk(clk), .res(res), .carry_in(c_ces_x0), .clear(zero_time),
        .digit(d_sec_0x), .carry_out(c_sec_0x)
    );
    bcd_digit #(.MAX(TENS_MAX)) u_sec_x0 (
        .clk(clk), .res(res), .carry_in(c_sec_0x), .clear(zero_time),
        .digit(d_sec_x0), .carry_out(c_sec_x0)
    );
    bcd_digit #(.MAX(UNITS_MAX)) u_min_0x (
        .clk(clk), .res(res), .carry_in(c_sec_x0), .clear(zero_time),
        .digit(d_min_0x), .carry_out(c_min_0x)
    );
    // The hour carry is dropped: 59:59.99 simply rolls over to 00:00.00.
    bcd_digit #(.MAX(TENS_MAX)) u_min_x0 (
        .clk(clk), .res(res), .carry_in(c_min_0x), .clear(zero_time),
        .digit(d_min_x0), .carry_out(carry_unused)
    );

    assign live = {d_min_x0, d_min_0x, d_sec_x0, d_sec_0x, d_ces_x0, d_ces_0x};

    always_comb begin
        state_d   = state_q;
        lap_d     = lap_q;
        zero_time = 1'b0;
        case (state_q)
            ST_STOPPED: begin
                if (clear_p) begin
                    zero_time = 1'b1;
                end else if (start_p) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (start_p) begin
                    state_d = ST_STOPPED;
                end else if (lap_p) begin
                    state_d = ST_LAP;
                    lap_d   = live;
                end
            end
            ST_LAP: begin
                if (start_p) begin
                    state_d = ST_STOPPED;
                end else if (lap_p) begin
                    state_d = ST_RUNNING;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
        running_d    = (state_d != ST_STOPPED);
        lap_active_d = (state_d == ST_LAP);
        disp_d       = disp_q;
        if (ena) begin
            disp_d = (state_q == ST_LAP) ? lap_q : live;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= ST_STOPPED;
            // NOTE: the lap register is an ordinary flop bank, not a RAM, so it is reset along with the rest.
            lap_q        <= '0;
            disp_q       <= '0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign clk_div    = clk_div_q;
    assign min_X0     = disp_q.min_x0;
    assign min_0X     = disp_q.min_0x;
    assign sec_X0     = disp_q.sec_x0;
    assign sec_0X     = disp_q.sec_0x;
    assign ces_X0     = disp_q.ces_x0;
    assign ces_0X     = disp_q.ces_0x;
    assign running    = running_q;
    assign lap_active = lap_active_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with PRESCALE=4: edges are counted from
// reset release, so ticks land on every 4th edge until a clear re-phases them.
module tb_stopwatch_counter;

    localparam int PRESCALE = 4;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        ena = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic        clk_div, running, lap_active;
    logic [2:0]  min_x0, sec_x0;
    logic [3:0]  min_0x, sec_0x, ces_x0, ces_0x;
    logic [23:0] disp;

    int tests    = 0;
    int fails    = 0;
    int edge_cnt = 0;
    int resync   = 0;

    stopwatch_counter #(.PRESCALE(PRESCALE)) dut (
        .clk(clk), .res(res), .ena(ena),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .clk_div(clk_div),
        .min_X0(min_x0), .min_0X(min_0x), .sec_X0(sec_x0), .sec_0X(sec_0x),
        .ces_X0(ces_x0), .ces_0X(ces_0x),
        .running(running), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    assign disp = {1'b0, min_x0, min_0x, 1'b0, sec_x0, sec_0x, ces_x0, ces_0x};

    always @(posedge clk or negedge res) begin
        if (!res) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    // clk_div must alternate in runs of exactly PRESCALE/2 cycles; a few
    // transitions are skipped after a reset or clear re-phases the prescaler.
    int   div_run = 0, div_skip = 3, div_bad = 0, div_checked = 0, resync_seen = 0;
    logic div_prev = 1'b1;
    always @(negedge clk) begin
        if (!res || resync != resync_seen) begin
            resync_seen = resync;
            div_skip    = 3;
            div_run     = 1;
            div_prev    = clk_div;
        end else if (clk_div == div_prev) begin
            div_run++;
        end else begin
            if (div_skip > 0) begin
                div_skip--;
            end else begin
                div_checked++;
                if (div_run != PRESCALE / 2) begin
                    div_bad++;
                    $display("FAIL clk_div_run: level %0b lasted %0d cycles, required %0d", div_prev, div_run, PRESCALE / 2);
                end
            end
            div_run  = 1;
            div_prev = clk_div;
        end
    end

    // Expected display in nibble form MMSSCC for a time given in centiseconds.
    function automatic logic [23:0] exp_time(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic goto_edge(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic press(input logic ss, input logic lp, input logic cl);
        int e0;
        e0 = edge_cnt;
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        goto_edge(e0 + 3);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic test_reset();
        #1 res = 1'b0;
        #1;
        tests++;
        if (disp !== 24'h000000) begin
            fails++; $display("FAIL reset_digits: got %h, required %h", disp, 24'h000000);
        end
        tests++;
        if ({clk_div, running, lap_active} !== 3'b100) begin
            fails++; $display("FAIL reset_flags: clk_div/running/lap_active got %b, required 100", {clk_div, running, lap_active});
        end
        repeat (2) @(negedge clk);
        res = 1'b1;
    endtask

    task automatic test_count_100();
        goto_edge(8);
        tests++;
        if (disp !== exp_time(0) || running !== 1'b0) begin
            fails++; $display("FAIL stopped_no_count: got %h running %b, required %h running 0", disp, running, exp_time(0));
        end
        start_stop = 1'b1;
        goto_edge(10);
        tests++;
        if (running !== 1'b0) begin
            fails++; $display("FAIL sync_early: running got %b after 2 edges, required 0", running);
        end
        goto_edge(11);
        tests++;
        if (running !== 1'b1) begin
            fails++; $display("FAIL sync_edge3: running got %b after 3 edges, required 1", running);
        end
        start_stop = 1'b0;
        goto_edge(408);
        tests++;
        if (disp !== exp_time(99)) begin
            fails++; $display("FAIL display_latency: got %h, required %h", disp, exp_time(99));
        end
        goto_edge(409);
        tests++;
        if (disp !== exp_time(100) || {running, lap_active} !== 2'b10) begin
            fails++; $display("FAIL count_100: got %h flags %b, required %h flags 10", disp, {running, lap_active}, exp_time(100));
        end
    endtask

    task automatic test_minute_carry();
        goto_edge(24005);
        tests++;
        if (disp !== exp_time(5999)) begin
            fails++; $display("FAIL at_59_99: got %h, required %h", disp, exp_time(5999));
        end
        goto_edge(24009);
        tests++;
        if (disp !== exp_time(6000)) begin
            fails++; $display("FAIL minute_carry: got %h, required %h", disp, exp_time(6000));
        end
        press(1'b1, 1'b0, 1'b0);
        goto_edge(24013);
        tests++;
        if (disp !== exp_time(6001) || running !== 1'b0) begin
            fails++; $display("FAIL stop_with_tick: got %h running %b, required %h running 0", disp, running, exp_time(6001));
        end
        goto_edge(24021);
        tests++;
        if (disp !== exp_time(6001)) begin
            fails++; $display("FAIL stopped_frozen: got %h, required %h", disp, exp_time(6001));
        end
    endtask

    task automatic test_hour_wrap();
        force dut.u_min_x0.digit_q = 3'd5;
        force dut.u_min_0x.digit_q = 4'd9;
        force dut.u_sec_x0.digit_q = 3'd5;
        force dut.u_sec_0x.digit_q = 4'd9;
        force dut.u_ces_x0.digit_q = 4'd9;
        force dut.u_ces_0x.digit_q = 4'd5;
        goto_edge(24022);
        release dut.u_min_x0.digit_q;
        release dut.u_min_0x.digit_q;
        release dut.u_sec_x0.digit_q;
        release dut.u_sec_0x.digit_q;
        release dut.u_ces_x0.digit_q;
        release dut.u_ces_0x.digit_q;
        tests++;
        if (disp !== exp_time(359995)) begin
            fails++; $display("FAIL preset_5959_95: got %h, required %h", disp, exp_time(359995));
        end
        press(1'b1, 1'b0, 1'b0);
        goto_edge(24041);
        tests++;
        if (disp !== exp_time(359999) || running !== 1'b1) begin
            fails++; $display("FAIL at_5959_99: got %h running %b, required %h running 1", disp, running, exp_time(359999));
        end
        goto_edge(24045);
        tests++;
        if (disp !== exp_time(0) || running !== 1'b1) begin
            fails++; $display("FAIL hour_wrap: got %h running %b, required %h running 1", disp, running, exp_time(0));
        end
    endtask

    task automatic test_lap();
        goto_edge(24192);
        press(1'b0, 1'b1, 1'b0);
        goto_edge(24196);
        tests++;
        if (disp !== exp_time(37) || {running, lap_active} !== 2'b11) begin
            fails++; $display("FAIL lap_enter: got %h flags %b, required %h flags 11", disp, {running, lap_active}, exp_time(37));
        end
        goto_edge(24232);
        tests++;
        if (disp !== exp_time(37) || lap_active !== 1'b1) begin
            fails++; $display("FAIL lap_hold: got %h lap_active %b, required %h lap_active 1", disp, lap_active, exp_time(37));
        end
        press(1'b0, 1'b1, 1'b0);
        goto_edge(24236);
        tests++;
        if (disp !== exp_time(47) || {running, lap_active} !== 2'b10) begin
            fails++; $display("FAIL lap_exit: got %h flags %b, required %h flags 10", disp, {running, lap_active}, exp_time(47));
        end
    endtask

    task automatic test_clear_ignored();
        goto_edge(25000);
        press(1'b0, 1'b0, 1'b1);
        goto_edge(25006);
        tests++;
        if (disp !== exp_time(240) || running !== 1'b1) begin
            fails++; $display("FAIL clear_running: got %h running %b, required %h running 1", disp, running, exp_time(240));
        end
    endtask

    task automatic test_back_to_back();
        goto_edge(26043);
        press(1'b1, 1'b0, 1'b0);
        goto_edge(26052);
        tests++;
        if (disp !== exp_time(500) || running !== 1'b0) begin
            fails++; $display("FAIL stop_at_5_00: got %h running %b, required %h running 0", disp, running, exp_time(500));
        end
        resync++;
        press(1'b1, 1'b0, 1'b1);
        goto_edge(26057);
        tests++;
        if (disp !== exp_time(0) || running !== 1'b0) begin
            fails++; $display("FAIL clear_priority: got %h running %b, required %h running 0", disp, running, exp_time(0));
        end
        press(1'b1, 1'b0, 1'b0);
        goto_edge(26064);
        tests++;
        if (disp !== exp_time(1) || running !== 1'b1) begin
            fails++; $display("FAIL prescaler_cleared: got %h running %b, required %h running 1", disp, running, exp_time(1));
        end
    endtask

    task automatic test_reset_mid_run();
        goto_edge(30997);
        tests++;
        if (disp !== exp_time(1234) || clk_div !== 1'b0) begin
            fails++; $display("FAIL at_12_34: got %h clk_div %b, required %h clk_div 0", disp, clk_div, exp_time(1234));
        end
        #2 res = 1'b0;
        #1;
        tests++;
        if (disp !== 24'h000000 || {clk_div, running, lap_active} !== 3'b100) begin
            fails++; $display("FAIL async_reset: got %h flags %b, required 000000 flags 100", disp, {clk_div, running, lap_active});
        end
        repeat (2) @(negedge clk);
        res        = 1'b1;
        start_stop = 1'b1;
        goto_edge(3);
        start_stop = 1'b0;
        goto_edge(4);
        tests++;
        if (disp !== exp_time(0)) begin
            fails++; $display("FAIL post_reset_early: got %h, required %h", disp, exp_time(0));
        end
        goto_edge(5);
        tests++;
        if (disp !== exp_time(1) || running !== 1'b1) begin
            fails++; $display("FAIL post_reset_first_tick: got %h running %b, required %h running 1", disp, running, exp_time(1));
        end
    endtask

    initial begin
        test_reset();
        test_count_100();
        test_minute_carry();
        test_hour_wrap();
        test_lap();
        test_clear_ignored();
        test_back_to_back();
        test_reset_mid_run();
        repeat (4) @(negedge clk);
        tests++;
        if (div_bad != 0 || div_checked < 1000) begin
            fails++; $display("FAIL clk_div_period: %0d bad runs of %0d checked, required 0 bad and at least 1000 checked", div_bad, div_checked);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
